// File: rtl/itch_msg_encoder.sv
// rtl/itch_msg_encoder.sv - ITCH 5.0 A/D/E/X message encoder onto a length-prefixed 64-bit stream.
// Optional live msg/drop counters under `define T2T_ITCH_ENC_STATS_EN.
module itch_msg_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_msg_type,
  input  logic [9:0]  in_symbol_idx,
  input  logic [63:0] in_ts,
  input  logic [63:0] in_order_id,
  input  logic        in_side,
  input  logic [31:0] in_qty,
  input  logic [63:0] in_symbol_key,
  input  logic [31:0] in_price,
  input  logic [63:0] in_match_num,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [63:0] m_tdata,
  output logic [7:0]  m_tkeep,
  output logic        m_tlast,
  output logic        unsup_pulse,
  output logic [31:0] msg_count,
  output logic [31:0] drop_count
);
  localparam int MSG_DATA_W = 64;

  typedef enum logic [0:0] {IDLE, SEND} state_e;

  state_e                  state_q, state_d;
  logic [319:0]            frame_q, frame_d;
  logic [2:0]              beat_q, beat_d;
  logic [2:0]              last_q, last_d;
  logic [7:0]              last_keep_q, last_keep_d;
  logic                    in_ready_q, in_ready_d;
  logic                    m_tvalid_q, m_tvalid_d;
  logic [MSG_DATA_W-1:0]   m_tdata_q, m_tdata_d;
  logic [7:0]              m_tkeep_q, m_tkeep_d;
  logic                    m_tlast_q, m_tlast_d;
  logic                    unsup_pulse_q, unsup_pulse_d;
  logic                    msg_inc, drop_inc;

  logic                    supported;
  logic [15:0]             msg_len;
  logic [2:0]              acc_last;
  logic [7:0]              acc_keep;
  logic [167:0]            hdr;
  logic [319:0]            be_msg;
  logic [319:0]            le_msg;
  logic                    unused_ts;

  assign unused_ts = ^in_ts[63:48];

  // Build the frame big-endian (byte 0 in the MSBs), then byte-swap so that
  // stream byte k lands at [8k+7:8k] and beat b is simply le_msg[64b +: 64].
  always_comb begin
    supported = 1'b1;
    msg_len   = 16'd0;
    acc_last  = 3'd0;
    acc_keep  = 8'h00;
    be_msg    = '0;
    le_msg    = '0;
    hdr       = '0;
    case (in_msg_type)
      8'h41:   begin msg_len = 16'd36; acc_last = 3'd4; acc_keep = 8'h3F; end
      8'h44:   begin msg_len = 16'd19; acc_last = 3'd2; acc_keep = 8'h1F; end
      8'h45:   begin msg_len = 16'd31; acc_last = 3'd4; acc_keep = 8'h01; end
      8'h58:   begin msg_len = 16'd23; acc_last = 3'd3; acc_keep = 8'h01; end
      default: supported = 1'b0;
    endcase
    hdr = {msg_len, in_msg_type, 6'd0, in_symbol_idx, 16'd0, in_ts[47:0], in_order_id};
    case (in_msg_type)
      8'h41:   be_msg = {hdr, (in_side ? 8'h53 : 8'h42), in_qty, in_symbol_key, in_price, 16'd0};
      8'h44:   be_msg = {hdr, 152'd0};
      8'h45:   be_msg = {hdr, in_qty, in_match_num, 56'd0};
      8'h58:   be_msg = {hdr, in_qty, 120'd0};
      default: be_msg = '0;
    endcase
    for (int k = 0; k < 40; k++) begin
      le_msg[8*k +: 8] = be_msg[319-8*k -: 8];
    end
  end

  always_comb begin
    state_d       = state_q;
    frame_d       = frame_q;
    beat_d        = beat_q;
    last_d        = last_q;
    last_keep_d   = last_keep_q;
    m_tvalid_d    = m_tvalid_q;
    m_tdata_d     = m_tdata_q;
    m_tkeep_d     = m_tkeep_q;
    m_tlast_d     = m_tlast_q;
    unsup_pulse_d = 1'b0;
    msg_inc       = 1'b0;
    drop_inc      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_ready_q && in_valid) begin
          if (supported) begin
            state_d     = SEND;
            frame_d     = le_msg;
            beat_d      = 3'd0;
            last_d      = acc_last;
            last_keep_d = acc_keep;
            m_tvalid_d  = 1'b1;
            m_tdata_d   = le_msg[63:0];
            m_tkeep_d   = 8'hFF;
            m_tlast_d   = 1'b0;
          end else begin
            unsup_pulse_d = 1'b1;
            drop_inc      = 1'b1;
          end
        end
      end
      SEND: begin
        if (m_tready) begin
          if (beat_q == last_q) begin
            state_d    = IDLE;
            m_tvalid_d = 1'b0;
            m_tdata_d  = '0;
            m_tkeep_d  = 8'h00;
            m_tlast_d  = 1'b0;
            msg_inc    = 1'b1;
          end else begin
            beat_d    = beat_q + 3'd1;
            m_tdata_d = frame_q[{beat_d, 6'd0} +: 64];
            m_tkeep_d = (beat_d == last_q) ? last_keep_q : 8'hFF;
            m_tlast_d = (beat_d == last_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      frame_q       <= '0;
      beat_q        <= 3'd0;
      last_q        <= 3'd0;
      last_keep_q   <= 8'h00;
      in_ready_q    <= 1'b0;
      m_tvalid_q    <= 1'b0;
      m_tdata_q     <= '0;
      m_tkeep_q     <= 8'h00;
      m_tlast_q     <= 1'b0;
      unsup_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_q       <= frame_d;
      beat_q        <= beat_d;
      last_q        <= last_d;
      last_keep_q   <= last_keep_d;
      in_ready_q    <= in_ready_d;
      m_tvalid_q    <= m_tvalid_d;
      m_tdata_q     <= m_tdata_d;
      m_tkeep_q     <= m_tkeep_d;
      m_tlast_q     <= m_tlast_d;
      unsup_pulse_q <= unsup_pulse_d;
    end
  end

`ifdef T2T_ITCH_ENC_STATS_EN
  logic [31:0] msg_count_q, msg_count_d;
  logic [31:0] drop_count_q, drop_count_d;

  always_comb begin
    msg_count_d  = msg_count_q + {31'd0, msg_inc};
    drop_count_d = drop_count_q + {31'd0, drop_inc};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      msg_count_q  <= 32'd0;
      drop_count_q <= 32'd0;
    end else begin
      msg_count_q  <= msg_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign msg_count  = msg_count_q;
  assign drop_count = drop_count_q;
`else
  logic unused_inc;
  assign unused_inc = msg_inc ^ drop_inc;
  assign msg_count  = 32'd0;
  assign drop_count = 32'd0;
`endif

  assign in_ready    = in_ready_q;
  assign m_tvalid    = m_tvalid_q;
  assign m_tdata     = m_tdata_q;
  assign m_tkeep     = m_tkeep_q;
  assign m_tlast     = m_tlast_q;
  assign unsup_pulse = unsup_pulse_q;
endmodule

// File: tb/tb_itch_msg_encoder.sv
// tb/tb_itch_msg_encoder.sv - randomized self-checking bench for itch_msg_encoder.
// Expected frames are built as byte queues directly from the ITCH field layout.
module tb_itch_msg_encoder;
  logic        clk, rst_n, in_valid, in_ready, in_side, m_tvalid, m_tready, m_tlast, unsup_pulse;
  logic [7:0]  in_msg_type, m_tkeep;
  logic [9:0]  in_symbol_idx;
  logic [63:0] in_ts, in_order_id, in_symbol_key, in_match_num, m_tdata;
  logic [31:0] in_qty, in_price, msg_count, drop_count;

  int checks = 0;
  int errors = 0;
  int exp_msg = 0;
  int exp_drop = 0;
  logic [7:0]  exp_bytes[$];
  logic [63:0] got_data[8];
  logic [7:0]  got_keep[8];
  logic        got_last[8];

  itch_msg_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_msg_type(in_msg_type), .in_symbol_idx(in_symbol_idx), .in_ts(in_ts),
    .in_order_id(in_order_id), .in_side(in_side), .in_qty(in_qty),
    .in_symbol_key(in_symbol_key), .in_price(in_price), .in_match_num(in_match_num),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .unsup_pulse(unsup_pulse), .msg_count(msg_count), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_be(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_bytes.push_back(v[8*i +: 8]);
  endtask

  // Message body laid out field by field; the length prefix is its byte count.
  task automatic build_frame();
    int len;
    exp_bytes.delete();
    exp_bytes.push_back(in_msg_type);
    push_be({54'd0, in_symbol_idx}, 2);
    push_be(64'd0, 2);
    push_be(in_ts, 6);
    push_be(in_order_id, 8);
    case (in_msg_type)
      8'h41: begin
        exp_bytes.push_back(in_side ? 8'h53 : 8'h42);
        push_be({32'd0, in_qty}, 4);
        push_be(in_symbol_key, 8);
        push_be({32'd0, in_price}, 4);
      end
      8'h45: begin push_be({32'd0, in_qty}, 4); push_be(in_match_num, 8); end
      8'h58: push_be({32'd0, in_qty}, 4);
      default: ;
    endcase
    len = exp_bytes.size();
    exp_bytes.push_front(len[7:0]);
    exp_bytes.push_front(len[15:8]);
  endtask

  task automatic set_msg(input logic [7:0] t, input logic [9:0] idx, input logic [63:0] ts,
                         input logic [63:0] oid, input logic side, input logic [31:0] qty,
                         input logic [63:0] key, input logic [31:0] price, input logic [63:0] mn);
    in_msg_type = t; in_symbol_idx = idx; in_ts = ts; in_order_id = oid; in_side = side;
    in_qty = qty; in_symbol_key = key; in_price = price; in_match_num = mn;
  endtask

  task automatic rand_msg(input logic [7:0] t);
    set_msg(t, 10'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
            $urandom, {$urandom, $urandom}, $urandom, {$urandom, $urandom});
  endtask

  task automatic check_counts(input string tag);
    int em, ed;
`ifdef T2T_ITCH_ENC_STATS_EN
    em = exp_msg; ed = exp_drop;
`else
    em = 0; ed = 0;
`endif
    checks++;
    if (msg_count !== 32'(em)) begin errors++; $display("FAIL %s msg_count got %0d exp %0d", tag, msg_count, em); end
    checks++;
    if (drop_count !== 32'(ed)) begin errors++; $display("FAIL %s drop_count got %0d exp %0d", tag, drop_count, ed); end
  endtask

  // Called at posedge+1 while idle: presents one request for exactly one edge.
  task automatic send_req(input string tag);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready before accept got %b exp 1", tag, in_ready); end
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,..., 2: random ready.
  task automatic collect(input string tag, input int mode);
    int nb, b, cyc;
    logic [63:0] ed, prev_d;
    logic [7:0]  ek, prev_k;
    logic        el, stalled, hs;
    nb = (exp_bytes.size() + 7) / 8;
    b = 0; cyc = 0; stalled = 1'b0; prev_d = '0; prev_k = '0;
    while (b < nb && cyc < 200) begin
      ed = '0; ek = '0;
      for (int k = 0; k < 8; k++) begin
        if (8*b + k < exp_bytes.size()) begin ed[8*k +: 8] = exp_bytes[8*b + k]; ek[k] = 1'b1; end
      end
      el = (b == nb - 1);
      case (mode)
        0:       m_tready = 1'b1;
        1:       m_tready = (cyc % 3 == 0);
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
      checks++;
      if (m_tvalid !== 1'b1) begin errors++; $display("FAIL %s beat%0d tvalid got %b exp 1", tag, b, m_tvalid); end
      checks++;
      if (m_tdata !== ed) begin errors++; $display("FAIL %s beat%0d tdata got %h exp %h", tag, b, m_tdata, ed); end
      checks++;
      if (m_tkeep !== ek) begin errors++; $display("FAIL %s beat%0d tkeep got %h exp %h", tag, b, m_tkeep, ek); end
      checks++;
      if (m_tlast !== el) begin errors++; $display("FAIL %s beat%0d tlast got %b exp %b", tag, b, m_tlast, el); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL %s beat%0d in_ready got %b exp 0", tag, b, in_ready); end
      if (stalled) begin
        checks++;
        if (m_tdata !== prev_d || m_tkeep !== prev_k) begin
          errors++; $display("FAIL %s stall_stable beat%0d got %h/%h exp %h/%h", tag, b, m_tdata, m_tkeep, prev_d, prev_k);
        end
      end
      got_data[b] = m_tdata; got_keep[b] = m_tkeep; got_last[b] = m_tlast;
      hs = m_tvalid && m_tready;
      prev_d = m_tdata; prev_k = m_tkeep; stalled = !m_tready;
      @(posedge clk); #1;
      if (hs) b++;
      cyc++;
    end
    m_tready = 1'b1;
    checks++;
    if (b != nb) begin errors++; $display("FAIL %s timeout beats got %0d exp %0d", tag, b, nb); end
    exp_msg++;
    checks++;
    if (m_tvalid !== 1'b0) begin errors++; $display("FAIL %s post_tvalid got %b exp 0", tag, m_tvalid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s post_in_ready got %b exp 1", tag, in_ready); end
    check_counts(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    exp_msg = 0; exp_drop = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({m_tvalid, m_tlast, unsup_pulse, in_ready} !== 4'b0000) begin
      errors++; $display("FAIL reset flags got %b exp 0000", {m_tvalid, m_tlast, unsup_pulse, in_ready});
    end
    checks++;
    if (m_tdata !== 64'd0 || m_tkeep !== 8'd0) begin errors++; $display("FAIL reset data got %h/%h exp 0/0", m_tdata, m_tkeep); end
    check_counts("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_add();
    set_msg(8'h41, 10'd5, 64'h0000_1122_3344_5566, 64'h1, 1'b1, 32'd100, 64'h4141_504C_2020_2020, 32'd1500000, 64'h0);
    build_frame();
    send_req("add");
    checks++;
    if (m_tdata !== 64'h1100_0005_0041_2400) begin errors++; $display("FAIL add_beat0 got %h exp 1100000500412400", m_tdata); end
    collect("add", 0);
    checks++;
    if (got_data[2][47:40] !== 8'h53) begin errors++; $display("FAIL add_side got %h exp 53", got_data[2][47:40]); end
    checks++;
    if (got_keep[4] !== 8'h3F || got_last[4] !== 1'b1) begin errors++; $display("FAIL add_last got %h/%b exp 3f/1", got_keep[4], got_last[4]); end
  endtask

  task automatic test_delete();
    rand_msg(8'h44);
    build_frame();
    send_req("delete");
    collect("delete", 0);
    checks++;
    if (got_data[0][15:0] !== 16'h1300) begin errors++; $display("FAIL delete_len got %h exp 1300", got_data[0][15:0]); end
    checks++;
    if (got_keep[2] !== 8'h1F) begin errors++; $display("FAIL delete_keep got %h exp 1f", got_keep[2]); end
  endtask

  task automatic test_executed_stall();
    rand_msg(8'h45);
    build_frame();
    send_req("exec");
    collect("exec", 1);
    checks++;
    if (got_keep[4] !== 8'h01) begin errors++; $display("FAIL exec_keep got %h exp 01", got_keep[4]); end
    checks++;
    if (got_data[4][7:0] !== in_match_num[7:0]) begin errors++; $display("FAIL exec_lastbyte got %h exp %h", got_data[4][7:0], in_match_num[7:0]); end
  endtask

  task automatic test_unsupported(input logic [7:0] t);
    rand_msg(t);
    send_req("unsup");
    exp_drop++;
    checks++;
    if (unsup_pulse !== 1'b1 || m_tvalid !== 1'b0) begin errors++; $display("FAIL unsup_pulse got %b/%b exp 1/0", unsup_pulse, m_tvalid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL unsup_in_ready got %b exp 1", in_ready); end
    check_counts("unsup");
    @(posedge clk); #1;
    checks++;
    if (unsup_pulse !== 1'b0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL unsup_after got %b/%b exp 0/0", unsup_pulse, m_tvalid); end
  endtask

  task automatic test_reset_mid_message();
    rand_msg(8'h58);
    send_req("midrst");
    m_tready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin errors++; $display("FAIL midrst got %b/%b exp 0/0", m_tvalid, m_tlast); end
    exp_msg = 0; exp_drop = 0;
    check_counts("midrst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    rand_msg(8'h41);
    build_frame();
    send_req("midrst_add");
    collect("midrst_add", 0);
  endtask

  task automatic test_back_to_back();
    rand_msg(8'h58);
    build_frame();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b in_ready got %b exp 1", in_ready); end
    in_valid = 1'b1;
    @(posedge clk); #1;
    collect("b2b_cancel", 0);
    rand_msg(8'h41);
    @(posedge clk); #1;
    in_valid = 1'b0;
    build_frame();
    collect("b2b_add", 0);
  endtask

  task automatic test_random();
    logic [7:0] types[4];
    logic [7:0] t;
    types[0] = 8'h41; types[1] = 8'h44; types[2] = 8'h45; types[3] = 8'h58;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        t = 8'($urandom);
        if (t == 8'h41 || t == 8'h44 || t == 8'h45 || t == 8'h58) t = 8'h00;
        test_unsupported(t);
      end else begin
        rand_msg(types[$urandom_range(0, 3)]);
        build_frame();
        send_req("random");
        collect("random", 2);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; m_tready = 1'b1;
    set_msg(8'h0, 10'd0, 64'd0, 64'd0, 1'b0, 32'd0, 64'd0, 32'd0, 64'd0);
    test_reset();
    test_add();
    test_delete();
    test_executed_stall();
    test_unsupported(8'h53);
    test_reset_mid_message();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
